// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product datapath stages: FSM state
// encoding, default widths and helpers that derive the signed saturation
// bounds for a given output width.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Default product width comes from the 64-bit multiplier plus 7 guard bits.
  localparam int DP_PWIDTH    = 64 + 7;
  localparam int DP_LEN_WIDTH = 10;
  localparam int DP_AWIDTH    = 81;
  localparam int DP_OWIDTH    = 64;

  // Saturation bounds are produced at this width and sliced by the user.
  localparam int DP_BOUND_WIDTH = 128;

  // Largest signed value representable in owidth bits: 2^(owidth-1)-1.
  function automatic logic [DP_BOUND_WIDTH-1:0] sat_max(input int owidth);
    return (DP_BOUND_WIDTH'(1) << (owidth - 1)) - DP_BOUND_WIDTH'(1);
  endfunction

  // Smallest signed value representable in owidth bits: -2^(owidth-1).
  function automatic logic [DP_BOUND_WIDTH-1:0] sat_min(input int owidth);
    return ~sat_max(owidth);
  endfunction

endpackage

// File: rtl/dp_sat_narrow.sv
// Arithmetic right shift followed by signed saturation from AWIDTH down to
// OWIDTH bits. Purely combinational so later layer stages can reuse it.
module dp_sat_narrow
  import dp_pkg::*;
#(
  parameter int AWIDTH = DP_AWIDTH,
  parameter int OWIDTH = DP_OWIDTH,
  parameter int SHIFT  = 0
) (
  input  logic signed [AWIDTH-1:0] value,
  output logic signed [OWIDTH-1:0] result,
  output logic                     sat
);

  if (SHIFT < 0 || SHIFT > AWIDTH - OWIDTH) begin : g_shift_check
    $error("dp_sat_narrow: SHIFT must lie in 0..AWIDTH-OWIDTH");
  end
  if (OWIDTH > DP_BOUND_WIDTH || OWIDTH >= AWIDTH) begin : g_width_check
    $error("dp_sat_narrow: OWIDTH must be below AWIDTH and at most 128");
  end

  localparam logic [DP_BOUND_WIDTH-1:0] MAX_FULL = sat_max(OWIDTH);
  localparam logic [DP_BOUND_WIDTH-1:0] MIN_FULL = sat_min(OWIDTH);
  localparam logic [OWIDTH-1:0]         OUT_MAX  = MAX_FULL[OWIDTH-1:0];
  localparam logic [OWIDTH-1:0]         OUT_MIN  = MIN_FULL[OWIDTH-1:0];

  logic signed [AWIDTH-1:0]   shifted;
  logic        [AWIDTH-OWIDTH:0] upper;

  // The shifted value fits when every bit from the output sign bit upward is
  // identical; otherwise clip toward the side given by the true sign.
  always_comb begin
    shifted = value >>> SHIFT;
    upper   = shifted[AWIDTH-1:OWIDTH-1];
    result  = shifted[OWIDTH-1:0];
    sat     = 1'b0;
    if (!(upper == '0 || upper == '1)) begin
      sat    = 1'b1;
      result = shifted[AWIDTH-1] ? OUT_MIN : OUT_MAX;
    end
  end

endmodule

// File: rtl/dp_accum.sv
// Accumulates len signed products from the multiplier and hands one
// shifted, saturated sum per dot product to the next layer stage.
module dp_accum
  import dp_pkg::*;
#(
  parameter int PWIDTH    = DP_PWIDTH,
  parameter int LEN_WIDTH = DP_LEN_WIDTH,
  parameter int AWIDTH    = DP_AWIDTH,
  parameter int OWIDTH    = DP_OWIDTH,
  parameter int SHIFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_WIDTH-1:0]     len,
  input  logic                     in_valid,
  input  logic signed [PWIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [OWIDTH-1:0] out_data,
  input  logic                     out_ready,
  output logic                     out_sat,
  output logic                     busy
);

  if (AWIDTH < PWIDTH + LEN_WIDTH) begin : g_awidth_check
    $error("dp_accum: AWIDTH must be >= PWIDTH + LEN_WIDTH");
  end

  state_t                   state;
  logic signed [AWIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]     count;
  logic [LEN_WIDTH-1:0]     len_q;
  logic signed [AWIDTH-1:0] product_ext;
  logic signed [AWIDTH-1:0] final_sum;
  logic signed [OWIDTH-1:0] narrow_data;
  logic                     narrow_sat;
  logic                     accept;
  logic                     last_term;

  // Handshake and status decode straight from the state register.
  always_comb begin
    in_ready    = (state == ACCUM);
    busy        = (state != IDLE);
    accept      = in_valid && in_ready;
    last_term   = (count == LEN_WIDTH'(len_q - 1'b1));
    product_ext = {{(AWIDTH-PWIDTH){in_data[PWIDTH-1]}}, in_data};
    final_sum   = acc + product_ext;
  end

  dp_sat_narrow #(
    .AWIDTH (AWIDTH),
    .OWIDTH (OWIDTH),
    .SHIFT  (SHIFT)
  ) u_sat_narrow (
    .value  (final_sum),
    .result (narrow_data),
    .sat    (narrow_sat)
  );

  // Control FSM with registered result; a reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      len_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q <= len;
              acc   <= '0;
              count <= '0;
              state <= ACCUM;
            end else begin
              out_data  <= '0;
              out_sat   <= 1'b0;
              out_valid <= 1'b1;
              state     <= OUTPUT;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= final_sum;
            count <= count + 1'b1;
            if (last_term) begin
              out_data  <= narrow_data;
              out_sat   <= narrow_sat;
              out_valid <= 1'b1;
              state     <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_accum.sv
// Directed and randomized checks of dp_accum. Two instances share one
// stimulus stream: one unshifted, one with SHIFT=4.
module tb_dp_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [9:0]         len;
  logic               in_valid;
  logic signed [70:0] in_data;
  logic               out_ready;

  logic               in_ready0, in_ready1;
  logic               out_valid0, out_valid1;
  logic signed [63:0] out_data0, out_data1;
  logic               out_sat0, out_sat1;
  logic               busy0, busy1;

  int passed = 0;
  int total  = 0;

  logic signed [127:0] prods[$];

  always #5 clk = ~clk;

  dp_accum #(.SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
    .out_sat(out_sat0), .busy(busy0)
  );

  dp_accum #(.SHIFT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
    .out_sat(out_sat1), .busy(busy1)
  );

  // Reference: exact sum, floor division by 2^sh, clamp to signed 64 bits.
  function automatic logic signed [127:0] modelOut(input logic signed [127:0] sum,
                                                   input int sh, output bit sat);
    logic signed [127:0] v, hi, lo;
    hi  = (128'sd1 <<< 63) - 128'sd1;
    lo  = -(128'sd1 <<< 63);
    v   = sum >>> sh;
    sat = 1'b0;
    if (v > hi) begin v = hi; sat = 1'b1; end
    else if (v < lo) begin v = lo; sat = 1'b1; end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [127:0] observed,
                             input logic signed [127:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  function automatic logic signed [127:0] randProduct(input bit wide);
    logic [95:0]        r;
    logic signed [70:0] t;
    r = {$urandom, $urandom, $urandom};
    t = r[70:0];
    if (!wide) t = 71'($signed(r[15:0]));
    return t;
  endfunction

  // Runs one job over the products in prods and checks it end to end.
  task automatic applyStimulus(input string name, input int gap, input int bp,
                               input bit pulse_start);
    logic signed [127:0] sum, e0, e1;
    bit s0, s1;
    int n;
    n   = prods.size();
    sum = 0;
    foreach (prods[i]) sum += prods[i];
    e0 = modelOut(sum, 0, s0);
    e1 = modelOut(sum, 4, s1);

    start = 1'b1;
    len   = n[9:0];
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      checkOutput({name, " in_ready"}, in_ready0, 1);
      in_valid = 1'b1;
      in_data  = prods[i][70:0];
      start    = pulse_start;
      len      = $urandom_range(1023, 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 71'($urandom);
      start    = 1'b0;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          start = pulse_start;
          len   = $urandom_range(1023, 0);
          checkOutput({name, " no early valid"}, out_valid0, 0);
          @(negedge clk);
          start = 1'b0;
        end
      end
    end

    checkOutput({name, " valid0"}, out_valid0, 1);
    checkOutput({name, " valid1"}, out_valid1, 1);
    checkOutput({name, " data0"}, out_data0, e0);
    checkOutput({name, " sat0"}, out_sat0, s0);
    checkOutput({name, " data1"}, out_data1, e1);
    checkOutput({name, " sat1"}, out_sat1, s1);
    checkOutput({name, " busy"}, busy0, 1);

    for (int c = 0; c < bp; c++) begin
      out_ready = 1'b0;
      start     = pulse_start;
      @(negedge clk);
      start = 1'b0;
      checkOutput({name, " hold valid"}, out_valid0, 1);
      checkOutput({name, " hold data"}, out_data0, e0);
      checkOutput({name, " hold in_ready"}, in_ready0, 0);
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, " done valid"}, out_valid0, 0);
    checkOutput({name, " done busy"}, busy0, 0);
    checkOutput({name, " done busy1"}, busy1, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", out_valid0, 0);
    checkOutput("reset out_data", out_data0, 0);
    checkOutput("reset out_sat", out_sat0, 0);
    checkOutput("reset in_ready", in_ready0, 0);
    checkOutput("reset busy", busy0, 0);
    rst = 1'b0;
    @(negedge clk);

    prods = '{128'sd5, -128'sd2, 128'sd10};
    applyStimulus("basic", 0, 0, 1'b0);

    prods = '{128'sd1, 128'sd2, 128'sd3, 128'sd4};
    applyStimulus("gaps", 2, 5, 1'b0);

    prods = '{(128'sd1 <<< 70) - 1, (128'sd1 <<< 70) - 1};
    applyStimulus("sat pos", 0, 1, 1'b0);

    prods = '{-(128'sd1 <<< 70), -(128'sd1 <<< 70)};
    applyStimulus("sat neg", 0, 1, 1'b0);

    prods = '{128'sd100, -128'sd3};
    applyStimulus("shift pos", 0, 0, 1'b0);

    prods = '{-128'sd17, 128'sd0};
    applyStimulus("shift floor", 0, 0, 1'b0);

    prods.delete();
    applyStimulus("len zero", 0, 2, 1'b0);

    prods = '{128'sd9, -128'sd4};
    applyStimulus("ignored start", 1, 2, 1'b1);

    // Abort a len=5 job after three accepts, then confirm a clean restart.
    start = 1'b1;
    len   = 10'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 71'(1000 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort out_valid", out_valid0, 0);
    checkOutput("abort out_data", out_data0, 0);
    checkOutput("abort in_ready", in_ready0, 0);
    checkOutput("abort busy", busy0, 0);
    checkOutput("abort out_sat", out_sat0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abort stays idle", out_valid0, 0);
    end
    prods = '{128'sd7};
    applyStimulus("after abort", 0, 0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      bit wide;
      int n;
      wide = (j % 2 == 0);
      n    = $urandom_range(8, 1);
      prods.delete();
      for (int k = 0; k < n; k++) prods.push_back(randProduct(wide));
      applyStimulus($sformatf("random%0d", j), $urandom_range(2, 0),
                    $urandom_range(3, 0), bit'($urandom_range(1, 0)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
